// File: rtl/pp_pkg.sv
// Shared pipeline definitions: default widths, MEM/WB control-bit layout and ALU opcodes.
// Used by the EX/MEM boundary (ex_mem_stage, pp_skid_buf) and by benches that build stimulus.
package pp_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam int CTRL_W         = 5;
  localparam int CTRL_REG_WRITE = 4;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_MEM_READ  = 2;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_BRANCH    = 0;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLT = 4'b0011,
    ALU_MUL = 4'b0100,
    ALU_SUB = 4'b0110,
    ALU_NOT = 4'b0111
  } alu_op_e;

  // x0 is hard-wired, so a write to it must never reach the register file.
  function automatic logic [CTRL_W-1:0] capture_ctrl(input logic [CTRL_W-1:0] ctrl,
                                                     input logic rd_is_zero);
    logic [CTRL_W-1:0] c;
    c = ctrl;
    if (rd_is_zero) c[CTRL_REG_WRITE] = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pp_skid_buf.sv
// Generic 2-entry valid/ready skid buffer over a packed payload.
// in_ready is registered (= skid empty), so upstream never sees a combinational path from out_ready.
module pp_skid_buf
  import pp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         main_load
);

  logic         main_valid_reg, main_valid_next;
  logic         skid_valid_reg, skid_valid_next;
  logic         in_ready_reg;
  logic [W-1:0] main_data_reg, skid_data_reg, main_data_next;
  logic         skid_load;
  logic         accept, drain, main_free;

  assign accept    = in_valid & in_ready_reg;
  assign drain     = main_valid_reg & out_ready;
  assign main_free = !main_valid_reg | drain;

  always_comb begin
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    main_data_next  = in_data;
    main_load       = 1'b0;
    skid_load       = 1'b0;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (skid_valid_reg) begin
      // in_ready was low, so no accept can coincide with the skid refill of main
      if (drain) begin
        main_load       = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (main_free) begin
        main_load       = 1'b1;
        main_valid_next = 1'b1;
      end else begin
        skid_load       = 1'b1;
        skid_valid_next = 1'b1;
      end
    end else if (drain) begin
      main_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= !skid_valid_next;
      if (main_load) main_data_reg <= main_data_next;
      if (skid_load) skid_data_reg <= in_data;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: skid-buffered capture, rd==0 write suppression, branch redirect.
// Define EX_MEM_PERF_CNT_EN to add the stall_cycles / branch_taken_cnt performance counters.
module ex_mem_stage
  import pp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic              in_zero_flag,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   in_branch_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_alu_result,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       branch_taken_cnt
`endif
);

  localparam int PW = 3 * XLEN + 1 + REG_AW + CTRL_W;

  logic [PW-1:0]     in_payload, main_payload;
  logic [CTRL_W-1:0] ctrl_cap;
  logic              main_zero;
  logic              main_load;
  logic              fresh_reg;

  assign ctrl_cap   = capture_ctrl(in_ctrl, in_rd == '0);
  assign in_payload = {in_alu_result, in_zero_flag, in_rs2_data, in_rd, ctrl_cap, in_branch_target};

  pp_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (main_payload),
    .main_load (main_load)
  );

  assign {out_alu_result, main_zero, out_rs2_data, out_rd, out_ctrl, redirect_pc} = main_payload;

  // Marks the first cycle a beat sits in main, so a taken branch redirects exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fresh_reg <= 1'b0;
    else     fresh_reg <= main_load;
  end

  assign redirect_valid = fresh_reg & out_ctrl[CTRL_BRANCH] & main_zero;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cycles_reg, branch_taken_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg <= '0;
      branch_taken_reg <= '0;
    end else begin
      if (out_valid & !out_ready) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (redirect_valid)         branch_taken_reg <= branch_taken_reg + 32'd1;
    end
  end

  assign stall_cycles     = stall_cycles_reg;
  assign branch_taken_cnt = branch_taken_reg;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed + randomized bench for ex_mem_stage against a queue-based model of the held beats.
// Build with +define+EX_MEM_PERF_CNT_EN to also check the performance counters.
module tb_ex_mem_stage;
  import pp_pkg::*;

  typedef struct {
    logic [31:0] alu;
    logic        z;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [4:0]  ctrl;
    logic [31:0] tgt;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_alu_result = '0;
  logic        in_zero_flag = 1'b0;
  logic [31:0] in_rs2_data = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_ctrl = '0;
  logic [31:0] in_branch_target = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_alu_result;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rd;
  logic [4:0]  out_ctrl;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] branch_taken_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  beat_t       q[$];
  logic        head_new = 1'b0;
  int unsigned m_stall = 0;
  int unsigned m_taken = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_alu_result    (in_alu_result),
    .in_zero_flag     (in_zero_flag),
    .in_rs2_data      (in_rs2_data),
    .in_rd            (in_rd),
    .in_ctrl          (in_ctrl),
    .in_branch_target (in_branch_target),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_alu_result   (out_alu_result),
    .out_rs2_data     (out_rs2_data),
    .out_rd           (out_rd),
    .out_ctrl         (out_ctrl),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
`ifdef EX_MEM_PERF_CNT_EN
    ,
    .stall_cycles     (stall_cycles),
    .branch_taken_cnt (branch_taken_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_redirect();
    return head_new && q.size() > 0 && q[0].ctrl[CTRL_BRANCH] && q[0].z;
  endfunction

  task automatic check_outputs();
    logic r;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_alu_result", out_alu_result, q[0].alu);
      chk("out_rs2_data", out_rs2_data, q[0].rs2);
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
      chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
    end
    r = exp_redirect();
    chk("redirect_valid", 32'(redirect_valid), 32'(r));
    if (r) chk("redirect_pc", redirect_pc, q[0].tgt);
`ifdef EX_MEM_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("branch_taken_cnt", branch_taken_cnt, m_taken);
`endif
  endtask

  task automatic set_beat(input logic [31:0] alu, input logic z, input logic [4:0] rd,
                          input logic [4:0] ctrl, input logic [31:0] tgt);
    in_alu_result    = alu;
    in_zero_flag     = z;
    in_rs2_data      = alu ^ 32'hA5A5_0000;
    in_rd            = rd;
    in_ctrl          = ctrl;
    in_branch_target = tgt;
  endtask

  task automatic rand_beat();
    in_alu_result    = $urandom;
    in_zero_flag     = 1'($urandom_range(0, 1));
    in_rs2_data      = $urandom;
    in_rd            = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    in_ctrl          = 5'($urandom);
    in_branch_target = $urandom & 32'hFFFF_FFFC;
  endtask

  // One clock: drive at negedge, update the model at posedge, check at the next negedge.
  task automatic step(input logic iv, input logic ordy, input logic fl);
    beat_t b;
    int    sz;
    logic  drain, acc;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    b.alu  = in_alu_result;
    b.z    = in_zero_flag;
    b.rs2  = in_rs2_data;
    b.rd   = in_rd;
    b.ctrl = in_ctrl;
    if (in_rd == 5'd0) b.ctrl[CTRL_REG_WRITE] = 1'b0;
    b.tgt  = in_branch_target;
    @(posedge clk);
    if (q.size() > 0 && !ordy) m_stall++;
    if (exp_redirect()) m_taken++;
    sz    = q.size();
    drain = sz > 0 && ordy;
    acc   = iv && sz < 2;
    if (fl) begin
      q.delete();
      head_new = 1'b0;
      $display("flush");
    end else begin
      if (drain) begin
        $display("deliver alu=%08h rd=%0d ctrl=%05b", q[0].alu, q[0].rd, q[0].ctrl);
        void'(q.pop_front());
      end
      if (acc) q.push_back(b);
      head_new = q.size() > 0 && (drain || sz == 0);
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Reset asserted between edges: effects must be visible without a clock edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    head_new = 1'b0;
    m_stall  = 0;
    m_taken  = 0;
    $display("async reset");
    check_outputs();
    chk("rst_out_alu", out_alu_result, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check_outputs();
    chk("rst_out_alu", out_alu_result, 32'h0);
    chk("rst_out_rs2", out_rs2_data, 32'h0);
    chk("rst_out_rd", 32'(out_rd), 32'h0);
    chk("rst_out_ctrl", 32'(out_ctrl), 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with no back-pressure
    for (int i = 1; i <= 4; i++) begin
      set_beat(32'(i * 16), 1'b0, 5'd7, 5'b10000, 32'h100);
      step(1'b1, 1'b1, 1'b0);
      chk("stream_alu", out_alu_result, 32'(i * 16));
    end
    step(1'b0, 1'b1, 1'b0);

    // Back-pressure: A lands in main, B in skid
    set_beat(32'h1111, 1'b0, 5'd1, 5'b10100, 32'h0);
    step(1'b1, 1'b0, 1'b0);
    set_beat(32'h2222, 1'b0, 5'd2, 5'b00010, 32'h0);
    step(1'b1, 1'b0, 1'b0);
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    set_beat(32'h3333, 1'b0, 5'd3, 5'b00000, 32'h0);
    step(1'b1, 1'b0, 1'b0);
    chk("bp_hold_alu", out_alu_result, 32'h1111);
    step(1'b0, 1'b1, 1'b0);
    chk("bp_b_alu", out_alu_result, 32'h2222);
    step(1'b0, 1'b1, 1'b0);

    // Branch taken and not taken
    set_beat(32'h0, 1'b1, 5'd0, 5'b00001, 32'h0000_0040);
    step(1'b1, 1'b1, 1'b0);
    chk("br_taken", 32'(redirect_valid), 32'h1);
    chk("br_pc", redirect_pc, 32'h40);
    step(1'b0, 1'b1, 1'b0);
    set_beat(32'h0, 1'b0, 5'd0, 5'b00001, 32'h0000_0040);
    step(1'b1, 1'b1, 1'b0);
    chk("br_not_taken", 32'(redirect_valid), 32'h0);

    // rd == 0 suppresses reg_write only
    set_beat(32'h55, 1'b0, 5'd0, 5'b11010, 32'h0);
    step(1'b1, 1'b1, 1'b0);
    chk("rd0_ctrl", 32'(out_ctrl), 32'b01010);
    step(1'b0, 1'b1, 1'b0);

    // Flush with both entries full and a beat on offer
    set_beat(32'hAAAA, 1'b1, 5'd4, 5'b00001, 32'h80);
    step(1'b1, 1'b0, 1'b0);
    set_beat(32'hBBBB, 1'b1, 5'd5, 5'b00001, 32'h90);
    step(1'b1, 1'b0, 1'b0);
    set_beat(32'hCCCC, 1'b1, 5'd6, 5'b00001, 32'hA0);
    step(1'b1, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

    // Async reset right after a taken-branch capture
    set_beat(32'hDEAD, 1'b1, 5'd8, 5'b00001, 32'hC0);
    step(1'b1, 1'b0, 1'b0);
    mid_reset();

    // Three stalled cycles, then async reset
    set_beat(32'hBEEF, 1'b0, 5'd9, 5'b10000, 32'h0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
`ifdef EX_MEM_PERF_CNT_EN
    chk("stall_before_rst", stall_cycles, 32'd2);
    step(1'b0, 1'b0, 1'b0);
    chk("stall_three", stall_cycles, 32'd3);
`endif
    mid_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0));
      if (i == 200) mid_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
